seq_detect_moore: RTL and testbench

Parametrised Moore-style serial pattern detector, the successor to our fixed 3-flop detector. It watches a 1-bit serial stream and recognises any compile-time pattern of width `PAT_W`. It supports sticky and pulse modes, overlapping and non-overlapping matching, and a per-bit valid qualifier, and it keeps a saturating match count. It sits directly behind the serial receive path and feeds the control logic.

---
 rtl/seq_detect_pkg.sv | 74 +++++++
 rtl/seq_detect_moore_sat_counter.sv | 35 +++
 rtl/seq_detect_moore.sv | 91 +++++++++
 tb/tb_seq_detect_moore.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared helpers for the serial pattern detector: elaboration-time KMP transition
// and border functions used to build constant next-state tables.
package seq_detect_pkg;

    // Widest pattern the helper functions are written to handle.
    localparam int unsigned PAT_W_MAX = 16;
    // Pattern width of the default build.
    localparam int unsigned PAT_W_DEF = 4;
    // State width of the default build; other widths come from state_w().
    localparam int unsigned SW = $clog2(PAT_W_DEF + 1);

    // State register width needed to hold 0..pat_w.
    function automatic int unsigned state_w(input int unsigned pat_w);
        return $clog2(pat_w + 1);
    endfunction

    // Longest prefix of the pattern that is also a suffix of (prefix(s) ++ bit).
    // Bit j of the pattern in arrival order is pattern[pat_w-1-j]. Requires s < pat_w.
    function automatic int unsigned kmp_next(input logic [15:0] pattern,
                                             input int unsigned pat_w,
                                             input int unsigned s,
                                             input logic        bit_i);
        int unsigned best;
        int unsigned pos;
        logic        ok;
        logic        tbit;
        best = 0;
        for (int unsigned k = 1; k <= PAT_W_MAX; k++) begin
            if (k <= s + 1 && k <= pat_w) begin
                ok = 1'b1;
                for (int unsigned j = 0; j < PAT_W_MAX; j++) begin
                    if (j < k) begin
                        pos = s + 1 - k + j;
                        if (pos == s) begin
                            tbit = bit_i;
                        end else begin
                            tbit = pattern[4'(pat_w - 1 - pos)];
                        end
                        if (pattern[4'(pat_w - 1 - j)] != tbit) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = k;
                end
            end
        end
        return best;
    endfunction

    // Longest proper prefix of the pattern that is also a suffix of it.
    function automatic int unsigned border(input logic [15:0] pattern,
                                           input int unsigned pat_w);
        int unsigned best;
        logic        ok;
        best = 0;
        for (int unsigned k = 1; k < PAT_W_MAX; k++) begin
            if (k < pat_w) begin
                ok = 1'b1;
                for (int unsigned j = 0; j < PAT_W_MAX; j++) begin
                    if (j < k && pattern[4'(pat_w - 1 - j)] != pattern[4'(k - 1 - j)]) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = k;
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_detect_moore_sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous reset.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q, q_d;

    // Next count: clear wins, otherwise increment unless already at all-ones.
    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != {W{1'b1}})) begin
            q_d = q_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/seq_detect_moore.sv
// Parametrised Moore serial pattern detector with sticky/pulse and
// overlapping/non-overlapping modes, a valid qualifier and a saturating match count.
module seq_detect_moore
    import seq_detect_pkg::*;
#(
    parameter int unsigned           PAT_W   = 4,
    parameter logic [PAT_W-1:0]      PATTERN = 4'b1001,
    parameter int unsigned           CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         data,
    input  logic                         valid,
    input  logic                         clear,
    input  logic                         sticky,
    input  logic                         overlap,
    output logic                         out,
    output logic [CNT_W-1:0]             match_count,
    output logic [$clog2(PAT_W+1)-1:0]   state_dbg
);

    localparam int unsigned        StateW = state_w(PAT_W);
    localparam logic [15:0]        PatExt = 16'(PATTERN);
    localparam logic [StateW-1:0]  MatchS = StateW'(PAT_W);
    localparam int unsigned        Border = border(PatExt, PAT_W);

    logic [StateW-1:0] state_q, state_d;
    logic              inc;

    // Constant transition tables; unused encodings above MATCH map to 0.
    logic [StateW-1:0] run_tbl [2**StateW][2];
    logic [StateW-1:0] ovl_tbl [2];

    for (genvar gs = 0; gs < 2**StateW; gs++) begin : g_run
        for (genvar gb = 0; gb < 2; gb++) begin : g_bit
            if (gs < PAT_W) begin : g_live
                assign run_tbl[gs][gb] = StateW'(kmp_next(PatExt, PAT_W, gs, 1'(gb)));
            end else begin : g_dead
                assign run_tbl[gs][gb] = '0;
            end
        end
    end

    for (genvar gb = 0; gb < 2; gb++) begin : g_ovl
        assign ovl_tbl[gb] = StateW'(kmp_next(PatExt, PAT_W, Border, 1'(gb)));
    end

    // Next state and match-count increment; clear outranks valid.
    always_comb begin
        state_d = state_q;
        inc     = 1'b0;
        if (clear) begin
            state_d = '0;
        end else if (valid) begin
            if (state_q != MatchS) begin
                state_d = run_tbl[state_q][data];
            end else if (sticky) begin
                state_d = state_q;
            end else if (overlap) begin
                state_d = ovl_tbl[data];
            end else begin
                state_d = run_tbl[0][data];
            end
            // A sticky hold is not a new match; an overlapped re-entry is.
            inc = (state_d == MatchS) && !((state_q == MatchS) && sticky);
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (clear),
        .inc (inc),
        .q   (match_count)
    );

    assign out       = (state_q == MatchS);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_detect_moore.sv
// Self-checking bench: directed streams, a history-based reference model compared
// every cycle, and hand-computed literal checks at the key points.
module tb_seq_detect_moore;

    localparam int unsigned PW  = 4;
    localparam logic [3:0]  PAT = 4'b1001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       data = 1'b0;
    logic       valid = 1'b0;
    logic       clear = 1'b0;
    logic       sticky = 1'b0;
    logic       overlap = 1'b1;
    logic       out_a, out_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;
    logic [2:0] st_a, st_b;

    int n_checks = 0;
    int n_errors = 0;
    logic cmp_en = 1'b0;

    seq_detect_moore #(.PAT_W(4), .PATTERN(4'b1001), .CNT_W(8)) dut_a (
        .clk (clk), .rst (rst), .data (data), .valid (valid), .clear (clear),
        .sticky (sticky), .overlap (overlap), .out (out_a), .match_count (cnt_a),
        .state_dbg (st_a)
    );

    seq_detect_moore #(.PAT_W(4), .PATTERN(4'b1001), .CNT_W(2)) dut_b (
        .clk (clk), .rst (rst), .data (data), .valid (valid), .clear (clear),
        .sticky (sticky), .overlap (overlap), .out (out_b), .match_count (cnt_b),
        .state_dbg (st_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the bits consumed since the last restart, plus a match flag.
    logic [15:0] m_hist, m_nhist;
    int          m_len, m_nlen;
    logic        m_out, m_nout, m_take;
    int          m_cnt8, m_cnt2;

    always_comb begin
        m_nhist = m_hist;
        m_nlen  = m_len;
        m_nout  = m_out;
        m_take  = valid && !(m_out && sticky);
        if (m_take) begin
            if (m_out && !overlap) begin
                m_nhist = '0;
                m_nlen  = 0;
            end
            m_nhist = {m_nhist[14:0], data};
            if (m_nlen < 16) m_nlen = m_nlen + 1;
            m_nout = (m_nlen >= PW) && (m_nhist[PW-1:0] == PAT);
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst || clear) begin
            m_hist <= '0;
            m_len  <= 0;
            m_out  <= 1'b0;
            m_cnt8 <= 0;
            m_cnt2 <= 0;
        end else begin
            m_hist <= m_nhist;
            m_len  <= m_nlen;
            m_out  <= m_nout;
            if (m_take && m_nout) begin
                m_cnt8 <= (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
                m_cnt2 <= (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
            end
        end
    end

    // Matched-bit count implied by the history: longest suffix equal to a pattern prefix.
    function automatic int exp_state(input logic [15:0] h, input int l, input logic o);
        logic [3:0] pv;
        int         best;
        logic       ok;
        pv   = PAT;
        best = 0;
        if (o) return PW;
        for (int k = 1; k < PW; k++) begin
            if (k <= l) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (h[4'(k - 1 - j)] != pv[2'(PW - 1 - j)]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_out_a", int'(out_a), int'(m_out));
            chk("model_out_b", int'(out_b), int'(m_out));
            chk("model_cnt8", int'(cnt_a), m_cnt8);
            chk("model_cnt2", int'(cnt_b), m_cnt2);
            chk("model_state", int'(st_a), exp_state(m_hist, m_len, m_out));
        end
    end

    task automatic step(input logic d, input logic v);
        data  = d;
        valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear(input logic v);
        clear = 1'b1;
        step(1'b1, v);
        clear = 1'b0;
    endtask

    // Sends n bits MSB-first and checks out after each edge against exp (MSB-first).
    task automatic send(input string tag, input logic [15:0] bits, input int n,
                        input logic [15:0] exp);
        for (int i = 0; i < n; i++) begin
            step(bits[4'(n - 1 - i)], 1'b1);
            chk(tag, int'(out_a), int'(exp[4'(n - 1 - i)]));
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("reset_out", int'(out_a), 0);
        chk("reset_state", int'(st_a), 0);
        chk("reset_cnt", int'(cnt_a), 0);
        rst = 1'b0;

        // Overlapping pulse mode: 1001001 matches twice.
        send("ovl_out", 16'b1001001, 7, 16'b0001001);
        chk("ovl_cnt", int'(cnt_a), 2);

        // Clear beats valid; then non-overlapping: one match only.
        do_clear(1'b1);
        chk("clr_prio_state", int'(st_a), 0);
        chk("clr_prio_cnt", int'(cnt_a), 0);
        overlap = 1'b0;
        send("novl_out", 16'b1001001, 7, 16'b0001000);
        chk("novl_cnt", int'(cnt_a), 1);
        chk("novl_state", int'(st_a), 1);

        // Sticky: out holds through further bits, count stays 1; clear drops both.
        do_clear(1'b0);
        sticky  = 1'b1;
        overlap = 1'b1;
        send("sticky_out", 16'b10010000, 8, 16'b00011111);
        chk("sticky_cnt", int'(cnt_a), 1);
        do_clear(1'b0);
        chk("sticky_clr_out", int'(out_a), 0);
        chk("sticky_clr_cnt", int'(cnt_a), 0);

        // Release sticky in MATCH: next valid 0 resumes from border 1 -> state 2.
        send("rel_out", 16'b1001, 4, 16'b0001);
        step(1'b1, 1'b1);
        chk("rel_hold_state", int'(st_a), 4);
        sticky = 1'b0;
        step(1'b0, 1'b1);
        chk("rel_state", int'(st_a), 2);
        chk("rel_cnt", int'(cnt_a), 1);

        // Valid gaps with toggling data hold state.
        do_clear(1'b0);
        for (int i = 0; i < 4; i++) begin
            step((i == 0 || i == 3) ? 1'b1 : 1'b0, 1'b1);
            chk("gap_state", int'(st_a), i + 1);
            for (int g = 0; g < 3; g++) begin
                step(g[0] ? 1'b0 : 1'b1, 1'b0);
                chk("gap_hold", int'(st_a), i + 1);
                chk("gap_out", int'(out_a), (i == 3) ? 1 : 0);
            end
        end
        chk("gap_cnt", int'(cnt_a), 1);

        // Asynchronous reset mid-cycle discards a partial match.
        send("pre_rst", 16'b100, 3, 16'b000);
        chk("pre_rst_state", int'(st_a), 3);
        rst = 1'b1;
        #2;
        chk("rst_out", int'(out_a), 0);
        chk("rst_state", int'(st_a), 0);
        chk("rst_cnt", int'(cnt_a), 0);
        rst = 1'b0;
        step(1'b1, 1'b1);
        chk("post_rst_state", int'(st_a), 1);
        chk("post_rst_out", int'(out_a), 0);

        // Back-to-back overlapping matches; 2-bit counter saturates at 3.
        do_clear(1'b0);
        for (int i = 0; i < 16; i++) begin
            step((i % 3 == 0) ? 1'b1 : 1'b0, 1'b1);
            if (i % 3 == 0 && i > 0) begin
                chk("sat_cnt2", int'(cnt_b), (i / 3 < 3) ? i / 3 : 3);
                chk("sat_cnt8", int'(cnt_a), i / 3);
            end
        end

        @(negedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
